fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter D_W, default 32, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, depth of the attached FIFO.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  when high, new FIFO reads are permitted.
REQ-006 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-007 SHALL have port fifo_data  input  D_W (signed)  FIFO read data, valid the cycle after fifo_read.
REQ-008 SHALL have port fifo_read  output  1  FIFO read strobe.
REQ-009 SHALL have port m_valid  output  1  downstream data valid.
REQ-010 SHALL have port m_ready  input  1  downstream ready.
REQ-011 SHALL have port m_data  output  D_W (signed)  downstream data.
REQ-012 SHALL have port beat_cnt  output  16  count of completed downstream transfers.
REQ-013 SHALL have port stall_cnt  output  16  count of cycles with m_valid=1 and m_ready=0.

Function
REQ-014 SHALL hold a 2-entry output buffer; buf_cnt is in {0,1,2}, with states EMPTY, ONE and TWO.
REQ-015 SHALL track inflight (0/1): set in the cycle after fifo_read=1, clear otherwise.
REQ-016 SHALL define pop = m_valid & m_ready.
REQ-017 SHALL drive fifo_read combinationally as en & !fifo_empty & ((buf_cnt + inflight - pop) < 2).
REQ-018 SHALL, when inflight=1, capture fifo_data into the buffer tail on that clock edge.
REQ-019 SHALL, on an edge with both capture and pop, complete the pop first and append the capture, with buf_cnt unchanged.
REQ-020 SHALL drive m_valid = (buf_cnt != 0) and m_data = buffer head; m_data is 0 when buf_cnt = 0.
REQ-021 SHALL keep m_data stable while m_valid=1 and m_ready=0.
REQ-022 SHALL deliver words in FIFO order with no loss or duplication.
REQ-023 SHALL have a first-word latency of 2 cycles (fifo_read in cycle N, m_valid in cycle N+2).
REQ-024 SHALL sustain 1 word/cycle when m_ready stays high and fifo_empty stays low.
REQ-025 SHALL, when en falls, complete any inflight capture and retain buffered data, but issue no new reads.
REQ-026 SHALL never overflow the buffer: buf_cnt + inflight <= 2 at every edge.
REQ-027 SHALL make transitions EMPTY->ONE on capture without pop, ONE->TWO on capture without pop, TWO->ONE on pop without capture, ONE->EMPTY on pop without capture, and otherwise hold state.

Reset
REQ-028 SHALL, while rst=0, asynchronously clear buf_cnt, inflight, the buffer contents, beat_cnt and stall_cnt.
REQ-029 SHALL drive fifo_read=0, m_valid=0 and m_data=0 during reset.
REQ-030 SHALL discard any word whose read was issued in the cycle before reset asserted.

Configuration
REQ-031 SHALL, with macro FIFO_RD_STREAM_STATS_EN defined, increment beat_cnt on each pop and stall_cnt on each stall cycle; both counters wrap 0xFFFF->0.
REQ-032 SHALL, without FIFO_RD_STREAM_STATS_EN, tie beat_cnt and stall_cnt to constant 0 and build no counter logic.

Verification
REQ-033 SHALL cover single word: FIFO holds 0x11, en=1, m_ready=1 -> fifo_read in cycle 0; m_valid=1 with m_data=0x11 in cycle 2 only; beat_cnt=1.
REQ-034 SHALL cover streaming: 8 words 1..8, m_ready=1 -> m_data = 1..8 in 8 consecutive cycles; fifo_read high for 8 consecutive cycles.
REQ-035 SHALL cover backpressure: 4 words, m_ready=0 for 5 cycles, then 1 -> reads stop at 2 buffered words; m_data holds 1 while stalled; output is then 1,2,3,4; stall_cnt=5 with STATS_EN.
REQ-036 SHALL cover en deassert: en drops in the cycle after fifo_read -> the inflight word is still delivered, and no further fifo_read occurs until en=1.
REQ-037 SHALL cover mid-stream reset: rst=0 with buf_cnt=2 -> m_valid=0 immediately; after release, the next data is the next FIFO word.
REQ-038 SHALL cover negative data: fifo_data = -5 -> m_data = -5 (0xFFFFFFFB), sign preserved.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Pulls words out of a FIFO with a one-cycle read latency and presents
//   them on a valid/ready stream through a two-entry skid buffer. Reads
//   are only issued when the word can be guaranteed a slot, so the buffer
//   never overflows and the stream can run at one word per cycle.
//
// Build option:
//   FIFO_RD_STREAM_STATS_EN - when defined, beat_cnt and stall_cnt count
//   transfers and stall cycles (both wrap at 16 bits). When undefined both
//   outputs are tied to zero.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   en          permits new FIFO reads
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after fifo_read
//   fifo_read   FIFO read strobe (combinational)
//   m_valid     downstream data valid
//   m_ready     downstream ready
//   m_data      downstream data (buffer head, zero when buffer empty)
//   beat_cnt    completed downstream transfers
//   stall_cnt   cycles with m_valid=1 and m_ready=0
//   dbg_state   buffer occupancy state (EMPTY=0, ONE=1, TWO=2)
//
// Handshake: a word transfers on every rising edge where m_valid and
// m_ready are both high. Once m_valid is raised it stays high and m_data
// stays constant until that transfer happens; m_valid never depends on
// m_ready.

module fifo_rd_stream #(
  parameter int D_W   = 32,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic signed [D_W-1:0] fifo_data,
  output logic                  fifo_read,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic signed [D_W-1:0] m_data,
  output logic [15:0]           beat_cnt,
  output logic [15:0]           stall_cnt,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  // A zero-depth FIFO can never supply a word; for any real FIFO this is 1.
  localparam logic DEPTH_OK = (DEPTH >= 1);

  buf_state_t           state_q, state_d;
  logic                 inflight_q;
  logic signed [D_W-1:0] head_q, tail_q;
  logic                 pop;
  logic                 capture;
  logic [2:0]           occ_after_pop;

  assign capture = inflight_q;
  assign m_valid = (state_q != EMPTY);
  assign pop     = m_valid & m_ready;
  assign m_data  = m_valid ? head_q : '0;
  assign dbg_state = state_q;

  // Occupancy counts words already buffered plus the one on its way; a pop
  // this cycle frees a slot, so it can be credited before issuing a read.
  // pop implies at least one buffered word, so this never underflows.
  assign occ_after_pop = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};

  // rst gates the strobe so nothing is read while held in reset.
  assign fifo_read = rst & DEPTH_OK & en & ~fifo_empty & (occ_after_pop < 3'd2);

  // Occupancy state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_read;
    end
  end

  // Next-state: capture and pop on the same edge cancel out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (capture)          state_d = ONE;
      ONE: begin
        if (capture && !pop)       state_d = TWO;
        else if (pop && !capture)  state_d = EMPTY;
      end
      TWO:   if (pop && !capture)  state_d = ONE;
      default:                     state_d = EMPTY;
    endcase
  end

  // Buffer data path. head_q is always the oldest word. On a simultaneous
  // pop and capture the pop completes first, then the new word is appended.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case ({capture, pop})
        2'b10: begin
          if (state_q == EMPTY) head_q <= fifo_data;
          else                  tail_q <= fifo_data;
        end
        2'b01: begin
          // With one word left the stale tail moves up but is masked by m_valid.
          head_q <= tail_q;
        end
        2'b11: begin
          if (state_q == TWO) begin
            head_q <= tail_q;
            tail_q <= fifo_data;
          end else begin
            head_q <= fifo_data;
          end
        end
        default: begin
          head_q <= head_q;
          tail_q <= tail_q;
        end
      endcase
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0] beat_q, stall_q;

  // Both counters wrap naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      if (pop)                beat_q  <= beat_q + 16'd1;
      if (m_valid && !m_ready) stall_q <= stall_q + 16'd1;
    end
  end

  assign beat_cnt  = beat_q;
  assign stall_cnt = stall_q;
`else
  assign beat_cnt  = 16'd0;
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
//   Bench for fifo_rd_stream. A source FIFO with one-cycle read latency
//   feeds the DUT; a reference model tracks every word read but not yet
//   delivered (with the cycle it was read) and derives the expected stream
//   outputs, read strobe and statistics each cycle.

module tb_fifo_rd_stream;

  localparam int D_W   = 32;
  localparam int DEPTH = 8;
  localparam int SRC_N = 4096;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic                  en = 1'b0;
  logic                  m_ready = 1'b0;
  logic                  fifo_empty;
  logic signed [D_W-1:0] fifo_data = '0;
  logic                  fifo_read;
  logic                  m_valid;
  logic signed [D_W-1:0] m_data;
  logic [15:0]           beat_cnt;
  logic [15:0]           stall_cnt;
  logic [1:0]            dbg_state;

  fifo_rd_stream #(.D_W(D_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .beat_cnt   (beat_cnt),
    .stall_cnt  (stall_cnt),
    .dbg_state  (dbg_state)
  );

  // Source FIFO: words pushed by the driver, popped by fifo_read with
  // data appearing the following cycle. Garbage otherwise.
  logic [D_W-1:0] src_mem [0:SRC_N-1];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_read) begin
      fifo_data <= src_mem[rd_ptr % SRC_N];
      rd_ptr    <= rd_ptr + 1;
    end else begin
      fifo_data <= $urandom;
    end
  end

  // Scoreboard / reference model
  logic [D_W-1:0] exp_q[$];
  int             tag_q[$];
  int             cyc = 0;
  logic [15:0]    beats = '0;
  logic [15:0]    stalls = '0;
  logic           exp_valid = 1'b0;
  logic           drain_done = 1'b0;
  int             n_cmp = 0;
  int             n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Model state advance: words leave on a transfer, join on a read.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      tag_q.delete();
      beats  <= '0;
      stalls <= '0;
    end else begin
      if (exp_valid && m_ready) begin
        void'(exp_q.pop_front());
        void'(tag_q.pop_front());
        beats <= beats + 16'd1;
      end
      if (exp_valid && !m_ready) stalls <= stalls + 16'd1;
      if (fifo_read) begin
        exp_q.push_back(src_mem[rd_ptr % SRC_N]);
        tag_q.push_back(cyc);
      end
      cyc <= cyc + 1;
    end
  end

  // Checker: away from the active edge, plus right after reset asserts.
  always begin
    int   outstanding;
    logic exp_pop;
    logic exp_read;
    logic [D_W-1:0] exp_data;
    @(negedge clk or negedge rst);
    if (!rst) begin
      #1;
      exp_valid = 1'b0;
      check("rst_m_valid",   {31'b0, m_valid},   32'd0);
      check("rst_m_data",    m_data,             32'd0);
      check("rst_fifo_read", {31'b0, fifo_read}, 32'd0);
      check("rst_beat_cnt",  {16'b0, beat_cnt},  32'd0);
      check("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
    end else begin
      outstanding = exp_q.size();
      // A word read in cycle N is presented from cycle N+2 onwards.
      exp_valid = (outstanding > 0) && (tag_q[0] <= cyc - 2);
      exp_data  = exp_valid ? exp_q[0] : '0;
      exp_pop   = exp_valid && m_ready;
      exp_read  = en && !fifo_empty && ((outstanding - int'(exp_pop)) < 2);
      check("m_valid",   {31'b0, m_valid},   {31'b0, exp_valid});
      check("m_data",    m_data,             exp_data);
      check("fifo_read", {31'b0, fifo_read}, {31'b0, exp_read});
`ifdef FIFO_RD_STREAM_STATS_EN
      check("beat_cnt",  {16'b0, beat_cnt},  {16'b0, beats});
      check("stall_cnt", {16'b0, stall_cnt}, {16'b0, stalls});
`else
      check("beat_cnt",  {16'b0, beat_cnt},  32'd0);
      check("stall_cnt", {16'b0, stall_cnt}, 32'd0);
`endif
      if (drain_done) begin
        check("drained_src", rd_ptr, wr_ptr);
        check("drained_buf", exp_q.size(), 32'd0);
        drain_done = 1'b0;
      end
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [D_W-1:0] w);
    src_mem[wr_ptr % SRC_N] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  initial begin
    // Reset held for a few cycles
    rst = 1'b0;
    step(3);
    rst = 1'b1;
    step(2);

    // Single word
    en = 1'b1;
    m_ready = 1'b1;
    push(32'h11);
    step(6);

    // Streaming 1..8
    for (int i = 1; i <= 8; i++) push(i);
    step(12);

    // Backpressure: 4 words, stalled for 5 cycles
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(i);
    step(5);
    m_ready = 1'b1;
    step(8);

    // en drops the cycle after the first read
    push(32'd100);
    push(32'd101);
    push(32'd102);
    step(1);
    en = 1'b0;
    step(5);
    en = 1'b1;
    step(6);

    // Negative data
    push(32'hFFFF_FFFB);
    step(5);

    // Mid-stream reset with the buffer full
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(32'd200 + i);
    step(4);
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    m_ready = 1'b1;
    step(10);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 7) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) push($urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        step(1);
        rst = 1'b1;
      end
      step(1);
    end

    // Drain with a bounded budget, then confirm nothing is left
    en = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (rd_ptr == wr_ptr && exp_q.size() == 0) break;
      step(1);
    end
    drain_done = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
